mult_rr_scheduler: RTL and testbench
====================================

Name: mult_rr_scheduler

Overview:
- Shares one pipelined signed multiplier among NUM_REQ requesters. The multiplier is a registered-I/O instance with 2 cycles of latency, like the booth4/ripple wrapper variants.
- Round-robin arbitration, one issue per cycle, valid/ready request handshake.
- Tracks in-flight ops by tag and returns each product with the originating requester ID.
- Sits between requester logic and a single multN wrapper instance in multiplier benchmark runs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 4, operand width; signed two's complement
- MULT_LAT, 2, cycles from mult_a/mult_b stable to mult_p valid (external multiplier latency)
- IDW, 2, requester ID width; must satisfy 2**IDW >= NUM_REQ

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant; handshake = valid & ready
- req_a  in  NUM_REQ*WIDTH  packed multiplicands; requester i at [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  packed multipliers, same packing
- hold  in  1  stop issuing new operations; in-flight ops still complete
- mult_a  out  WIDTH  registered operand to multiplier multiplicand
- mult_b  out  WIDTH  registered operand to multiplier multiplier
- mult_p  in  2*WIDTH  product from multiplier
- rsp_valid  out  1  registered response valid; single-cycle pulse; no backpressure
- rsp_id  out  IDW  requester ID of the response
- rsp_product  out  2*WIDTH  signed product
- busy  out  1  high when any operation is in flight or issuing
- stat_sel  in  IDW  statistics counter select
- stat_count  out  16  selected grant counter

Behaviour:
Reset (async, rst=1):
- req_ready=0, mult_a=0, mult_b=0, rsp_valid=0, rsp_id=0, rsp_product=0, busy=0.
- Round-robin pointer=0; in-flight pipe cleared; state=IDLE.
- Counters cleared.

Arbitration:
- Combinational. Grant the first i with req_valid[i], searching from the pointer upward with wrap.
- req_ready is one-hot or zero. It is 0 for every requester when hold=1 or in reset.
- req_ready may depend on req_valid. Requesters must not gate req_valid on req_ready, and must hold operands stable while valid.
- On a handshake with requester g: pointer <= (g+1) mod NUM_REQ. With no handshake the pointer is unchanged.
- Requests with index >= NUM_REQ do not exist. IDs wrap to 0 past NUM_REQ-1.

Issue:
- Handshake in cycle c loads mult_a/mult_b with the winner's operands at the end of c.
- mult_a/mult_b hold their value when there is no issue.

Tag pipe:
- Shift register, depth MULT_LAT+1, each entry {valid, id}.
- The entry entering in cycle c is sampled against mult_p in cycle c+1+MULT_LAT.
- rsp_valid/rsp_id/rsp_product are registered from that stage, so rsp_valid is high in cycle c+MULT_LAT+2. This is 4 cycles with defaults.
- rsp_product = mult_p captured raw, 2*WIDTH bits.
- Full throughput: back-to-back issues give back-to-back responses in issue order.

State machine:
- IDLE: no in-flight ops, no handshake.
  - Go to ISSUE on any handshake.
- ISSUE: issuing or in flight, hold=0.
  - Go to DRAIN when hold=1 and in-flight != 0.
  - Go to IDLE when the pipe is empty and there is no handshake.
- DRAIN: hold=1, no grants, in-flight ops retire.
  - Go to IDLE when the pipe is empty.
  - Go to ISSUE if hold drops while ops are in flight.
- busy = (state != IDLE) | any tag valid.

Boundary conditions:
- hold rising in the same cycle as valid: no grant that cycle.
- Simultaneous valid from all requesters: grants proceed in pointer order, one per cycle.
- A single requester with continuous valid is granted every cycle.
- rst mid-operation: all in-flight ops are discarded and no rsp_valid follows. Requesters must re-issue.

Optional Feature:
- Macro MULT_SCHED_STATS_EN.
- Defined: one 16-bit saturating grant counter per requester, incremented on that requester's handshake and held at 16'hFFFF. stat_count = counter[stat_sel], combinational. stat_sel >= NUM_REQ returns 0.
- Undefined: no counters are built. stat_count is tied to 0 and stat_sel is ignored.

Test Plan:
- Single op: req 2 with a=3, b=-2 (4'hE) handshake in cycle 5 -> rsp_valid in cycle 9, rsp_id=2, rsp_product=8'hFA.
- Signed corners: req0 a=-8, b=-8 -> 8'h40; req1 a=-8, b=7 -> 8'hC8; req3 a=7, b=7 -> 8'h31.
- Contention: all 4 valid from reset -> grant order 0,1,2,3,0, one per cycle. Responses are back-to-back, rsp_id in the same order, no gaps.
- Fairness: req1 and req3 always valid, pointer at 2 -> grants alternate 3,1,3,1.
- Hold/drain: hold=1 with 2 ops in flight -> req_ready=0, both responses still arrive, busy drops the cycle after the last rsp_valid. Releasing hold resumes grants from the saved pointer.
- Reset mid-flight: assert rst 1 cycle after 3 issues -> outputs go to 0 immediately, no rsp_valid afterward. With MULT_SCHED_STATS_EN, stat_count=0 after reset and reads 3 for a requester granted 3 times.

Source files
------------

// File: rtl/mult_rr_scheduler.sv
// rtl/mult_rr_scheduler.sv - round-robin scheduler sharing one pipelined signed multiplier
// Optional per-requester grant counters: define MULT_SCHED_STATS_EN.
module mult_rr_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 4,
  parameter int MULT_LAT = 2,
  parameter int IDW      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic                     hold,
  output logic [WIDTH-1:0]         mult_a,
  output logic [WIDTH-1:0]         mult_b,
  input  logic [2*WIDTH-1:0]       mult_p,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [2*WIDTH-1:0]       rsp_product,
  output logic                     busy,
  input  logic [IDW-1:0]           stat_sel,
  output logic [15:0]              stat_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                     state, state_nxt;
  logic [IDW-1:0]             ptr;
  logic [MULT_LAT:0]          tag_v;
  logic [MULT_LAT:0][IDW-1:0] tag_id;
  logic                       found_hi, found_lo, gnt_found, hs, inflight;
  logic [IDW-1:0]             id_hi, id_lo, gnt_id;
  logic [WIDTH-1:0]           sel_a, sel_b;

  // Round-robin pick: first valid at or above the pointer, else first valid from index 0
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    id_hi    = '0;
    id_lo    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_hi && req_valid[i] && (i >= int'(ptr))) begin
        found_hi = 1'b1;
        id_hi    = IDW'(i);
      end
      if (!found_lo && req_valid[i]) begin
        found_lo = 1'b1;
        id_lo    = IDW'(i);
      end
    end
    gnt_found = found_hi | found_lo;
    gnt_id    = found_hi ? id_hi : id_lo;
  end

  assign hs       = !rst && !hold && gnt_found;
  assign inflight = |tag_v;

  // One-hot grant plus operand mux for the winner
  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        req_ready[i] = hs;
        sel_a        = req_a[i*WIDTH +: WIDTH];
        sel_b        = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer, operand registers, tag pipe and response capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      mult_a      <= '0;
      mult_b      <= '0;
      tag_v       <= '0;
      tag_id      <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
    end else begin
      if (hs) begin
        ptr    <= (gnt_id == IDW'(NUM_REQ-1)) ? '0 : gnt_id + IDW'(1);
        mult_a <= sel_a;
        mult_b <= sel_b;
      end
      tag_v     <= {tag_v[MULT_LAT-1:0], hs};
      tag_id    <= {tag_id[MULT_LAT-1:0], gnt_id};
      rsp_valid <= tag_v[MULT_LAT];
      if (tag_v[MULT_LAT]) begin
        rsp_id      <= tag_id[MULT_LAT];
        rsp_product <= mult_p;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: idle once nothing is in flight or entering; drain while hold keeps ops retiring
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         if (hs) state_nxt = ISSUE;
      ISSUE, DRAIN: begin
        if (!inflight && !hs) state_nxt = IDLE;
        else if (hold)        state_nxt = DRAIN;
        else                  state_nxt = ISSUE;
      end
      default:      state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE) || inflight;

`ifdef MULT_SCHED_STATS_EN
  logic [15:0] grant_cnt [NUM_REQ];

  // Saturating per-requester grant counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs && (gnt_id == IDW'(i)) && (grant_cnt[i] != 16'hFFFF))
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
      end
    end
  end

  // Counter readback; unused select codes read zero
  always_comb begin
    stat_count = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (stat_sel == IDW'(i)) stat_count = grant_cnt[i];
    end
  end
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_count      = '0;
`endif

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// tb/tb_mult_rr_scheduler.sv - scoreboard bench for mult_rr_scheduler with random and directed traffic
module tb_mult_rr_scheduler;
  localparam int N   = 4;
  localparam int W   = 4;
  localparam int LAT = 2;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic             hold = 1'b0;
  logic [W-1:0]     mult_a, mult_b;
  logic [2*W-1:0]   mult_p;
  logic             rsp_valid;
  logic [IDW-1:0]   rsp_id;
  logic [2*W-1:0]   rsp_product;
  logic             busy;
  logic [IDW-1:0]   stat_sel = '0;
  logic [15:0]      stat_count;

  mult_rr_scheduler #(.NUM_REQ(N), .WIDTH(W), .MULT_LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .hold(hold), .mult_a(mult_a), .mult_b(mult_b),
    .mult_p(mult_p), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product),
    .busy(busy), .stat_sel(stat_sel), .stat_count(stat_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External multiplier: registered I/O, LAT cycles from operands to product
  logic [2*W-1:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= {{W{mult_a[W-1]}}, mult_a} * {{W{mult_b[W-1]}}, mult_b};
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mult_p = mpipe[LAT-1];

  typedef struct {
    int             id;
    logic [2*W-1:0] p;
    int             due;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  int   mptr;
  int   last_issue;
  int   gcount [N];
  logic vq [N];
  int   aq [N];
  int   bq [N];
  int   g;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int exp_stat(input int sel);
`ifdef MULT_SCHED_STATS_EN
    return (sel < N) ? gcount[sel] : 0;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    sbq.delete();
    mptr       = 0;
    last_issue = -1000;
    for (int i = 0; i < N; i++) gcount[i] = 0;
  endtask

  function automatic int rnd_op();
    return int'($urandom_range(0, 15)) - 8;
  endfunction

  // One cycle: drive, predict the grant, check, record the expected response, advance
  task automatic step(output int gw);
    int        d;
    logic [31:0] pv;
    for (int i = 0; i < N; i++) begin
      req_valid[i]     = vq[i];
      req_a[i*W +: W]  = W'(aq[i]);
      req_b[i*W +: W]  = W'(bq[i]);
    end
    #1;
    gw = -1;
    if (!hold) begin
      for (int k = 0; k < N; k++) begin
        int i = (mptr + k) % N;
        if (gw < 0 && vq[i]) gw = i;
      end
    end
    chk("req_ready", 32'(req_ready), (gw >= 0) ? (32'd1 << gw) : 32'd0);
    d = cyc - last_issue;
    chk("busy", 32'(busy), 32'((d >= 1) && (d <= LAT + 2)));
    chk("stat_count", 32'(stat_count), 32'(exp_stat(int'(stat_sel))));
    if (gw >= 0) begin
      pv = aq[gw] * bq[gw];
      sbq.push_back('{id: gw, p: pv[2*W-1:0], due: cyc + LAT + 2});
      mptr       = (gw + 1) % N;
      last_issue = cyc;
      if (gcount[gw] < 65535) gcount[gw]++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_req();
    for (int i = 0; i < N; i++) vq[i] = 1'b0;
  endtask

  task automatic drain(input int n);
    int gd;
    clear_req();
    repeat (n) step(gd);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every response must match the oldest outstanding expectation, on its due cycle
  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].due < cyc) begin
      e = sbq.pop_front();
      total++;
      bad++;
      $display("FAIL missed_rsp: got none expected id=%0d product=%0h at cycle %0d", e.id, e.p, e.due);
    end
    if (!rst && rsp_valid) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got id=%0d product=%0h expected none (cycle %0d)", rsp_id, rsp_product, cyc);
      end else begin
        e = sbq.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_product", 32'(rsp_product), 32'(e.p));
        chk("rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    model_reset();
    clear_req();
    for (int i = 0; i < N; i++) begin aq[i] = 0; bq[i] = 0; end

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mult_a", 32'(mult_a), 32'd0);
    chk("rst_mult_b", 32'(mult_b), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_product", 32'(rsp_product), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single op: requester 2, 3 * -2
    vq[2] = 1'b1; aq[2] = 3; bq[2] = -2;
    step(g);
    drain(7);

    // Signed corners
    vq[0] = 1'b1; aq[0] = -8; bq[0] = -8;
    vq[1] = 1'b1; aq[1] = -8; bq[1] = 7;
    vq[3] = 1'b1; aq[3] = 7;  bq[3] = 7;
    repeat (3) begin
      step(g);
      if (g >= 0) vq[g] = 1'b0;
    end
    drain(6);

    // Contention from reset: everyone valid, new operands after each grant
    do_reset();
    for (int i = 0; i < N; i++) begin vq[i] = 1'b1; aq[i] = rnd_op(); bq[i] = rnd_op(); end
    repeat (5) begin
      step(g);
      if (g >= 0) begin aq[g] = rnd_op(); bq[g] = rnd_op(); end
    end
    drain(6);

    // Fairness: move pointer to 2, then requesters 1 and 3 stay valid
    vq[1] = 1'b1;
    step(g);
    vq[1] = 1'b1; vq[3] = 1'b1;
    repeat (4) step(g);
    drain(6);

    // Hold with two ops in flight, then release
    vq[0] = 1'b1; aq[0] = rnd_op(); bq[0] = rnd_op();
    vq[2] = 1'b1; aq[2] = rnd_op(); bq[2] = rnd_op();
    repeat (2) begin
      step(g);
      if (g >= 0) vq[g] = 1'b0;
    end
    vq[1] = 1'b1; vq[3] = 1'b1;
    hold = 1'b1;
    repeat (7) step(g);
    hold = 1'b0;
    repeat (4) step(g);
    drain(6);

    // Random traffic with random hold
    repeat (400) begin
      hold     = ($urandom_range(0, 9) == 0);
      stat_sel = IDW'($urandom_range(0, N - 1));
      step(g);
      if (g >= 0) begin
        vq[g] = 1'($urandom_range(0, 1));
        aq[g] = rnd_op();
        bq[g] = rnd_op();
      end
      for (int i = 0; i < N; i++) begin
        if (!vq[i] && $urandom_range(0, 2) == 0) begin
          vq[i] = 1'b1; aq[i] = rnd_op(); bq[i] = rnd_op();
        end
      end
    end
    hold = 1'b0;
    drain(8);

    // Reset mid-flight after three grants to requester 1
    do_reset();
    vq[1] = 1'b1; aq[1] = 5; bq[1] = -3;
    repeat (3) step(g);
    clear_req();
    stat_sel = IDW'(1);
    #1;
    chk("stat_after_3", 32'(stat_count), 32'(exp_stat(1)));
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_mult_a", 32'(mult_a), 32'd0);
    chk("midrst_mult_b", 32'(mult_b), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_stat", 32'(stat_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drain(10);

    chk("leftover_expected", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
